out_display: RTL
================

Name: out_display

Overview:
- Downstream consumer of the SAP-1 core's 8-bit result bus (MEM_OUT / output register value).
- Converts a captured binary byte to 3-digit BCD using a sequential double-dabble engine.
- Drives a time-multiplexed common-cathode 7-segment display with leading-zero blanking.
- Single clock domain, same clock as the core.

Parameters:
- REFRESH_DIV, 1024: clocks each digit stays enabled before the scan advances; legal range >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- load  in  1  single-cycle capture strobe for value.
- value  in  8  binary byte to display.
- busy  out  1  high while a conversion is in progress.
- valid  out  1  one-cycle pulse when a new bcd result is committed.
- bcd  out  12  last completed result: [11:8] hundreds, [7:4] tens, [3:0] ones.
- seg  out  7  segment drive, active-high; bit0=a ... bit6=g.
- dig  out  4  one-hot digit enable: bit0=ones, bit1=tens, bit2=hundreds, bit3=sign.

Behaviour:
- Reset (rst=0, async): state=IDLE, busy=0, valid=0, bcd=12'h000, refresh counter=0, dig=4'b0001, seg=7'h3F.
- Conversion FSM states: IDLE, SHIFT.
- IDLE, load=1: capture value into a 20-bit scratch {12'b0, value}; iteration count=0; busy=1; next state SHIFT.
- IDLE, load=0: hold all state.
- SHIFT, each cycle:
  - Add 3 to every scratch BCD nibble >= 5.
  - Shift scratch left by 1.
  - Increment iteration count.
- SHIFT, 8th cycle:
  - Write scratch[19:8] to bcd.
  - valid=1 for exactly the following cycle; busy=0; return to IDLE.
- Latency: load sampled at edge N; bcd/valid/busy update at edge N+8. Back-to-back load is accepted at edge N+8's cycle, so the next capture is at edge N+9.
- load while busy=1 is ignored; no queueing.
- valid is 0 in every cycle except the commit pulse.
- Max value 255 gives bcd 0x255; the hundreds nibble never exceeds 2.
- Display always shows bcd, never scratch, so the old value stays visible during a conversion.
- Refresh counter counts 0..REFRESH_DIV-1.
  - On wrap, dig advances ones -> tens -> hundreds -> ones (sign digit only with macro).
  - REFRESH_DIV=1 advances every cycle.
- seg is combinational from the current dig and bcd.
- Digit encoding: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Nibbles A-F are unreachable; drive 00.
- Leading-zero blanking (seg=00):
  - Hundreds digit blanked when hundreds=0.
  - Tens digit blanked when hundreds=0 and tens=0.
  - Ones digit is never blanked.
- Reset mid-conversion aborts the conversion: no valid pulse, and bcd returns to 000.
- Conversion and scanning run independently; a digit switch coincident with a commit shows the new bcd immediately.

Optional Feature:
- Macro: OUT_DISPLAY_SIGNED_EN.
- With the macro:
  - value is two's complement; the magnitude (|value|, so 8'h80 -> 128) is converted.
  - A neg flag is registered at the commit edge.
  - Scan covers 4 digits; the sign digit shows 40 ('-') when neg=1, else 00.
  - neg resets to 0.
- Without the macro:
  - value is unsigned.
  - Scan covers 3 digits only; dig[3] is held 0.

Test Plan:
1. Reset: assert rst=0 mid-run with REFRESH_DIV=4 -> busy=0, valid=0, bcd=000, dig=0001, seg=3F; after release, dig steps 0001 -> 0010 -> 0100 -> 0001 every 4 clocks.
2. Max value: load=1 with value=255 -> busy high 8 cycles, single valid pulse, bcd=12'h255; scan shows seg 6D/6D/5B for ones/tens/hundreds.
3. Blanking: load value=7 -> bcd=007; ones seg=07; tens and hundreds seg=00. Then load value=40 -> bcd=040; ones=3F, tens=66, hundreds=00.
4. Load while busy: load 42, then load 100 three cycles later -> second load ignored, exactly one valid pulse, bcd=042. Back-to-back load 99 on the commit cycle -> bcd=099 nine cycles later.
5. Reset mid-conversion: rst=0 four cycles after load 200 -> no valid pulse, bcd=000. After release, load 0 -> bcd=000, ones seg=3F.
6. Signed (OUT_DISPLAY_SIGNED_EN): value=8'h80 -> bcd=128, sign digit seg=40; value=8'hF9 -> bcd=007 with '-'; value=8'h05 -> sign digit seg=00.

Source files
------------

// File: rtl/out_display_if.sv
// ---------------------------------------------------------------------------
// out_display_if
// Bundles the capture strobe, the conversion status and the display drive
// of the out_display block.
//   load  : single-cycle capture strobe for value
//   value : byte to be shown
//   busy  : conversion in progress
//   valid : one-cycle pulse when a new bcd result is committed
//   bcd   : last completed result {hundreds, tens, ones}
//   seg   : active-high segments, bit0=a .. bit6=g
//   dig   : one-hot digit enable, bit0=ones .. bit3=sign
// Modports: master drives load/value (the producer), slave is the display.
// ---------------------------------------------------------------------------
interface out_display_if;
    logic        load;
    logic [7:0]  value;
    logic        busy;
    logic        valid;
    logic [11:0] bcd;
    logic [6:0]  seg;
    logic [3:0]  dig;

    modport master (
        output load, value,
        input  busy, valid, bcd, seg, dig
    );

    modport slave (
        input  load, value,
        output busy, valid, bcd, seg, dig
    );
endinterface

// File: rtl/out_display.sv
// ---------------------------------------------------------------------------
// out_display
// Captures a byte from the core's result bus, converts it to three BCD
// digits with a sequential double-dabble engine (8 cycles), and scans the
// result onto a multiplexed common-cathode 7-segment display with
// leading-zero blanking.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : out_display_if.slave (load/value in; busy/valid/bcd/seg/dig out)
// Parameters:
//   REFRESH_DIV : clocks each digit stays enabled (>= 1)
// Optional feature macro: OUT_DISPLAY_SIGNED_EN
//   When defined, value is two's complement, its magnitude is converted and
//   a fourth (sign) digit showing '-' is added to the scan.
// ---------------------------------------------------------------------------
module out_display #(
    parameter int REFRESH_DIV = 1024
) (
    input  logic          clk,
    input  logic          rst,
    out_display_if.slave  bus
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(REFRESH_DIV - 1);

    state_t        state;
    logic [19:0]   scratch;
    logic [19:0]   next_scratch;
    logic [2:0]    iter;
    logic [11:0]   bcd_q;
    logic          busy_q;
    logic          valid_q;
    logic [7:0]    magnitude;
    logic [CW-1:0] refresh_cnt;
    logic [3:0]    dig_q;
    logic [6:0]    seg_d;

    // One double-dabble step: correct every BCD nibble >= 5, then shift.
    function automatic logic [19:0] dabble_step(input logic [19:0] s);
        logic [19:0] a;
        a = s;
        if (a[11:8]  >= 4'd5) a[11:8]  = a[11:8]  + 4'd3;
        if (a[15:12] >= 4'd5) a[15:12] = a[15:12] + 4'd3;
        if (a[19:16] >= 4'd5) a[19:16] = a[19:16] + 4'd3;
        return {a[18:0], 1'b0};
    endfunction

    function automatic logic [6:0] digit_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign next_scratch = dabble_step(scratch);

`ifdef OUT_DISPLAY_SIGNED_EN
    logic neg_q;
    logic neg_pend;

    // Two's-complement magnitude; 8'h80 maps to 128, which still fits 8 bits.
    assign magnitude = bus.value[7] ? (~bus.value + 8'd1) : bus.value;
`else
    assign magnitude = bus.value;
`endif

    // Conversion FSM: capture in IDLE, eight dabble steps in SHIFT, commit
    // on the last step. Loads seen while in SHIFT are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            scratch  <= '0;
            iter     <= '0;
            bcd_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
`ifdef OUT_DISPLAY_SIGNED_EN
            neg_q    <= 1'b0;
            neg_pend <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        scratch  <= {12'b0, magnitude};
                        iter     <= '0;
                        busy_q   <= 1'b1;
                        state    <= SHIFT;
`ifdef OUT_DISPLAY_SIGNED_EN
                        neg_pend <= bus.value[7];
`endif
                    end
                end
                SHIFT: begin
                    scratch <= next_scratch;
                    iter    <= iter + 3'd1;
                    if (iter == 3'd7) begin
                        bcd_q   <= next_scratch[19:8];
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
`ifdef OUT_DISPLAY_SIGNED_EN
                        neg_q   <= neg_pend;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Scan timer: each digit is held for REFRESH_DIV clocks, independent of
    // the conversion engine.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_cnt <= '0;
            dig_q       <= 4'b0001;
        end else if (refresh_cnt == LAST_COUNT) begin
            refresh_cnt <= '0;
            case (dig_q)
                4'b0001: dig_q <= 4'b0010;
                4'b0010: dig_q <= 4'b0100;
`ifdef OUT_DISPLAY_SIGNED_EN
                4'b0100: dig_q <= 4'b1000;
                4'b1000: dig_q <= 4'b0001;
`else
                4'b0100: dig_q <= 4'b0001;
`endif
                default: dig_q <= 4'b0001;
            endcase
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Segment decode from the committed result only, so the previous value
    // stays visible while a conversion runs.
    always_comb begin
        seg_d = 7'h00;
        case (dig_q)
            4'b0001: seg_d = digit_seg(bcd_q[3:0]);
            4'b0010: seg_d = (bcd_q[11:4] == 8'h00) ? 7'h00 : digit_seg(bcd_q[7:4]);
            4'b0100: seg_d = (bcd_q[11:8] == 4'h0) ? 7'h00 : digit_seg(bcd_q[11:8]);
`ifdef OUT_DISPLAY_SIGNED_EN
            4'b1000: seg_d = neg_q ? 7'h40 : 7'h00;
`endif
            default: seg_d = 7'h00;
        endcase
    end

    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
    assign bus.bcd   = bcd_q;
    assign bus.dig   = dig_q;
    assign bus.seg   = seg_d;

endmodule
